// File: rtl/dis_pkg.sv
// -----------------------------------------------------------------------------
// dis_pkg
// Shared definitions for the dispatch controller: sizing constants, the
// one-hot FSM state type and the CU-id to resource-table-group mapping.
// -----------------------------------------------------------------------------
package dis_pkg;

  localparam int NUMBER_CU            = 8;
  localparam int CU_ID_WIDTH          = 3;
  localparam int RES_TABLE_ADDR_WIDTH = 2;
  localparam int NUMBER_RES_TABLE     = 1 << RES_TABLE_ADDR_WIDTH;
  localparam int STARVE_LIMIT         = 4;
  localparam int STARVE_CNT_W         = 3;

  typedef logic [CU_ID_WIDTH-1:0]          cu_id_t;
  typedef logic [RES_TABLE_ADDR_WIDTH-1:0] grp_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_ALLOC  = 4'b0010,
    ST_HANDLE = 4'b0100,
    ST_ACK    = 4'b1000
  } dis_state_e;

  // A group is the upper RES_TABLE_ADDR_WIDTH bits of the CU id.
  function automatic grp_t group_of(input cu_id_t cu);
    return cu[CU_ID_WIDTH-1 -: RES_TABLE_ADDR_WIDTH];
  endfunction

endpackage

// File: rtl/dis_issue_arb.sv
// -----------------------------------------------------------------------------
// dis_issue_arb
// Chooses between a dealloc candidate and an alloc/reject candidate on the
// shared issue path. Dealloc normally wins; after STARVE_LIMIT consecutive
// dealloc wins over a ready alloc, the alloc is forced through.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   d_cand_i          dealloc candidate ready (its group is unlocked)
//   a_cand_i          alloc candidate ready (waiting, group unlocked, path ok)
//   a_rejected_i      the waiting decision is a reject
//   issue_dealloc_o   one-hot issue select: dealloc
//   issue_alloc_o     one-hot issue select: alloc
//   issue_reject_o    one-hot issue select: reject
// -----------------------------------------------------------------------------
module dis_issue_arb
  import dis_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_cand_i,
  input  logic a_cand_i,
  input  logic a_rejected_i,
  output logic issue_dealloc_o,
  output logic issue_alloc_o,
  output logic issue_reject_o
);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    a_win;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    a_win           = a_cand_i & (~d_cand_i | (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT)));
    issue_dealloc_o = d_cand_i & ~a_win;
    issue_alloc_o   = a_win & ~a_rejected_i;
    issue_reject_o  = a_win & a_rejected_i;
    starve_cnt_d    = starve_cnt_q;
    if (a_win) begin
      starve_cnt_d = '0;
    end else if (a_cand_i && d_cand_i) begin
      // Only a dealloc win against a ready alloc counts as starvation.
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dis_controller_v2.sv
// -----------------------------------------------------------------------------
// dis_controller_v2
// Dispatch controller for the CTA scheduler. Sequences a workgroup allocation
// (start -> allocator decision -> issue -> ack), retains the allocator
// decision until it actually issues, arbitrates alloc/dealloc issue against a
// per-group lock vector and flags completions that hit an unlocked group.
// Ports:
//   clk, rst                               clock, async active-high reset
//   inflight_wg_buffer_alloc_valid_i       WG pending for allocation
//   inflight_wg_buffer_alloc_available_i   buffer can supply WG data
//   allocator_cu_valid_i/_rejected_i/_id_out_i  allocator decision
//   grt_wg_alloc_done_i/_cu_id_i           GRT finished an alloc
//   grt_wg_dealloc_done_i/_cu_id_i         GRT finished a dealloc
//   gpu_interface_alloc_available_i        interface can accept alloc
//   gpu_interface_dealloc_available_i      interface has a dealloc request
//   gpu_interface_cu_id_i                  CU of the dealloc request
//   dis_controller_*_o                     registered one-cycle pulses,
//                                          busy vector and sticky error
// -----------------------------------------------------------------------------
module dis_controller_v2
  import dis_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inflight_wg_buffer_alloc_valid_i,
  input  logic                   inflight_wg_buffer_alloc_available_i,
  input  logic                   allocator_cu_valid_i,
  input  logic                   allocator_cu_rejected_i,
  input  logic [CU_ID_WIDTH-1:0] allocator_cu_id_out_i,
  input  logic                   grt_wg_alloc_done_i,
  input  logic [CU_ID_WIDTH-1:0] grt_wg_alloc_cu_id_i,
  input  logic                   grt_wg_dealloc_done_i,
  input  logic [CU_ID_WIDTH-1:0] grt_wg_dealloc_cu_id_i,
  input  logic                   gpu_interface_alloc_available_i,
  input  logic                   gpu_interface_dealloc_available_i,
  input  logic [CU_ID_WIDTH-1:0] gpu_interface_cu_id_i,
  output logic                   dis_controller_start_alloc_o,
  output logic                   dis_controller_alloc_ack_o,
  output logic                   dis_controller_wg_alloc_valid_o,
  output logic                   dis_controller_wg_dealloc_valid_o,
  output logic                   dis_controller_wg_rejected_valid_o,
  output logic [NUMBER_CU-1:0]   dis_controller_cu_busy_o,
  output logic                   dis_controller_err_o
);

  dis_state_e                  state_q, state_d;
  logic [NUMBER_RES_TABLE-1:0] lock_q, lock_d, lock_set, lock_clr;
  logic                        alloc_waiting_q, alloc_waiting_d;
  cu_id_t                      wait_id_q, wait_id_d;
  logic                        wait_rej_q, wait_rej_d;
  logic                        start_q, start_d, ack_q, ack_d;
  logic                        alloc_q, dealloc_q, reject_q;
  logic                        err_q, err_d;
  logic                        capture;
  logic                        d_cand, a_cand;
  logic                        issue_dealloc, issue_alloc, issue_reject;

  // Candidates are qualified against the registered lock vector only.
  always_comb begin
    d_cand = gpu_interface_dealloc_available_i & ~lock_q[group_of(gpu_interface_cu_id_i)];
    a_cand = alloc_waiting_q & ~lock_q[group_of(wait_id_q)] &
             (wait_rej_q | (gpu_interface_alloc_available_i &
                            inflight_wg_buffer_alloc_available_i));
  end

  dis_issue_arb u_arb (
    .clk             (clk),
    .rst             (rst),
    .d_cand_i        (d_cand),
    .a_cand_i        (a_cand),
    .a_rejected_i    (wait_rej_q),
    .issue_dealloc_o (issue_dealloc),
    .issue_alloc_o   (issue_alloc),
    .issue_reject_o  (issue_reject)
  );

  // Allocation sequencing FSM.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    ack_d   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (inflight_wg_buffer_alloc_valid_i && !(&lock_q)) begin
          state_d = ST_ALLOC;
          start_d = 1'b1;
        end
      end
      ST_ALLOC: begin
        if (allocator_cu_valid_i) begin
          state_d = ST_HANDLE;
          capture = 1'b1;
        end
      end
      ST_HANDLE: begin
        if (!alloc_waiting_q) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The waiting decision survives until it issues, whatever the interface or
  // buffer availability does in the meantime.
  always_comb begin
    alloc_waiting_d = alloc_waiting_q;
    wait_id_d       = wait_id_q;
    wait_rej_d      = wait_rej_q;
    if (issue_alloc || issue_reject) begin
      alloc_waiting_d = 1'b0;
    end
    if (capture) begin
      alloc_waiting_d = 1'b1;
      wait_id_d       = allocator_cu_id_out_i;
      wait_rej_d      = allocator_cu_rejected_i;
    end
  end

  // Both completions may land together; sets only target unlocked groups, so
  // set and clear never collide on the same bit.
  always_comb begin
    lock_set = '0;
    lock_clr = '0;
    if (grt_wg_alloc_done_i)   lock_clr[group_of(grt_wg_alloc_cu_id_i)]   = 1'b1;
    if (grt_wg_dealloc_done_i) lock_clr[group_of(grt_wg_dealloc_cu_id_i)] = 1'b1;
    if (issue_dealloc)         lock_set[group_of(gpu_interface_cu_id_i)]  = 1'b1;
    if (issue_alloc)           lock_set[group_of(wait_id_q)]              = 1'b1;
    lock_d = (lock_q & ~lock_clr) | lock_set;
    err_d  = err_q |
             (grt_wg_alloc_done_i   & ~lock_q[group_of(grt_wg_alloc_cu_id_i)]) |
             (grt_wg_dealloc_done_i & ~lock_q[group_of(grt_wg_dealloc_cu_id_i)]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      lock_q          <= '0;
      alloc_waiting_q <= 1'b0;
      wait_id_q       <= '0;
      wait_rej_q      <= 1'b0;
      start_q         <= 1'b0;
      ack_q           <= 1'b0;
      alloc_q         <= 1'b0;
      dealloc_q       <= 1'b0;
      reject_q        <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      lock_q          <= lock_d;
      alloc_waiting_q <= alloc_waiting_d;
      wait_id_q       <= wait_id_d;
      wait_rej_q      <= wait_rej_d;
      start_q         <= start_d;
      ack_q           <= ack_d;
      alloc_q         <= issue_alloc;
      dealloc_q       <= issue_dealloc;
      reject_q        <= issue_reject;
      err_q           <= err_d;
    end
  end

  // Each CU reports the lock of the group it belongs to.
  always_comb begin
    dis_controller_cu_busy_o = '0;
    for (int i = 0; i < NUMBER_CU; i++) begin
      dis_controller_cu_busy_o[i] = lock_q[group_of(cu_id_t'(i))];
    end
  end

  assign dis_controller_start_alloc_o       = start_q;
  assign dis_controller_alloc_ack_o         = ack_q;
  assign dis_controller_wg_alloc_valid_o    = alloc_q;
  assign dis_controller_wg_dealloc_valid_o  = dealloc_q;
  assign dis_controller_wg_rejected_valid_o = reject_q;
  assign dis_controller_err_o               = err_q;

endmodule

// File: tb/tb_dis_controller_v2.sv
// -----------------------------------------------------------------------------
// tb_dis_controller_v2
// Directed scenarios followed by a randomized run, all checked every cycle
// against a behavioural model of the dispatch rules kept in this bench.
// -----------------------------------------------------------------------------
module tb_dis_controller_v2;
  import dis_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       buf_valid, buf_avail, alloc_cu_valid, alloc_rej;
  logic [2:0] alloc_cu_id;
  logic       alloc_done, dealloc_done;
  logic [2:0] alloc_done_cu, dealloc_done_cu;
  logic       gpu_alloc_av, gpu_dealloc_av;
  logic [2:0] gpu_cu;
  logic       start_o, ack_o, alloc_o, dealloc_o, reject_o, err_o;
  logic [7:0] busy_o;

  always #5 clk = ~clk;

  dis_controller_v2 dut (
    .clk                                  (clk),
    .rst                                  (rst),
    .inflight_wg_buffer_alloc_valid_i     (buf_valid),
    .inflight_wg_buffer_alloc_available_i (buf_avail),
    .allocator_cu_valid_i                 (alloc_cu_valid),
    .allocator_cu_rejected_i              (alloc_rej),
    .allocator_cu_id_out_i                (alloc_cu_id),
    .grt_wg_alloc_done_i                  (alloc_done),
    .grt_wg_alloc_cu_id_i                 (alloc_done_cu),
    .grt_wg_dealloc_done_i                (dealloc_done),
    .grt_wg_dealloc_cu_id_i               (dealloc_done_cu),
    .gpu_interface_alloc_available_i      (gpu_alloc_av),
    .gpu_interface_dealloc_available_i    (gpu_dealloc_av),
    .gpu_interface_cu_id_i                (gpu_cu),
    .dis_controller_start_alloc_o         (start_o),
    .dis_controller_alloc_ack_o           (ack_o),
    .dis_controller_wg_alloc_valid_o      (alloc_o),
    .dis_controller_wg_dealloc_valid_o    (dealloc_o),
    .dis_controller_wg_rejected_valid_o   (reject_o),
    .dis_controller_cu_busy_o             (busy_o),
    .dis_controller_err_o                 (err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_ALLOC = 1, P_HANDLE = 2, P_ACK = 3;
  bit m_lock[4];
  int m_phase, m_wait_cu, m_starve;
  bit m_wait, m_wait_rej, m_err;
  bit e_start, e_ack, e_alloc, e_dealloc, e_rej;

  function automatic int grp(input int cu);
    return cu / 2;  // eight CUs spread over four groups, two per group
  endfunction

  function automatic logic [7:0] exp_busy();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = m_lock[grp(i)];
    return b;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 4; g++) m_lock[g] = 1'b0;
    m_phase = P_IDLE; m_wait_cu = 0; m_starve = 0;
    m_wait = 0; m_wait_rej = 0; m_err = 0;
    e_start = 0; e_ack = 0; e_alloc = 0; e_dealloc = 0; e_rej = 0;
  endtask

  task automatic model_step();
    bit dc, ac, win_a, all_l, old_wait;
    bit nl[4];
    int dg, ag;
    dg = grp(int'(gpu_cu));
    ag = grp(m_wait_cu);
    dc = gpu_dealloc_av && !m_lock[dg];
    ac = m_wait && !m_lock[ag] && (m_wait_rej || (gpu_alloc_av && buf_avail));
    win_a = ac && (!dc || m_starve == STARVE_LIMIT);
    e_dealloc = dc && !win_a;
    e_alloc   = win_a && !m_wait_rej;
    e_rej     = win_a && m_wait_rej;
    if (win_a) m_starve = 0;
    else if (ac && dc) m_starve = m_starve + 1;
    all_l = m_lock[0] && m_lock[1] && m_lock[2] && m_lock[3];
    for (int g = 0; g < 4; g++) nl[g] = m_lock[g];
    if (alloc_done) begin
      if (!m_lock[grp(int'(alloc_done_cu))]) m_err = 1;
      nl[grp(int'(alloc_done_cu))] = 0;
    end
    if (dealloc_done) begin
      if (!m_lock[grp(int'(dealloc_done_cu))]) m_err = 1;
      nl[grp(int'(dealloc_done_cu))] = 0;
    end
    if (e_dealloc) nl[dg] = 1;
    if (e_alloc)   nl[ag] = 1;
    for (int g = 0; g < 4; g++) m_lock[g] = nl[g];
    old_wait = m_wait;
    if (win_a) m_wait = 0;
    e_start = 0; e_ack = 0;
    case (m_phase)
      P_IDLE:   if (buf_valid && !all_l) begin m_phase = P_ALLOC; e_start = 1; end
      P_ALLOC:  if (alloc_cu_valid) begin
                  m_phase = P_HANDLE; m_wait = 1;
                  m_wait_cu = int'(alloc_cu_id); m_wait_rej = alloc_rej;
                end
      P_HANDLE: if (!old_wait) begin m_phase = P_ACK; e_ack = 1; end
      default:  m_phase = P_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check("start_alloc", start_o, e_start);
    check("alloc_ack", ack_o, e_ack);
    check("wg_alloc_valid", alloc_o, e_alloc);
    check("wg_dealloc_valid", dealloc_o, e_dealloc);
    check("wg_rejected_valid", reject_o, e_rej);
    check("cu_busy", busy_o, exp_busy());
    check("err", err_o, m_err);
  endtask

  // Advance one clock: model consumes the current inputs, DUT samples them,
  // outputs are compared 1 time unit after the edge.
  task automatic tick();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    buf_valid = 0; buf_avail = 1; alloc_cu_valid = 0; alloc_rej = 0; alloc_cu_id = 0;
    alloc_done = 0; alloc_done_cu = 0; dealloc_done = 0; dealloc_done_cu = 0;
    gpu_alloc_av = 1; gpu_dealloc_av = 0; gpu_cu = 0;
  endtask

  // Return every locked group to free using dealloc completions.
  task automatic drain();
    idle_inputs();
    for (int g = 0; g < 4; g++) begin
      if (m_lock[g]) begin
        dealloc_done = 1; dealloc_done_cu = 3'(2 * g);
        tick();
        dealloc_done = 0;
      end
    end
    repeat (3) tick();
  endtask

  function automatic logic [2:0] pick_done_cu();
    int lst[4];
    int n = 0;
    for (int g = 0; g < 4; g++) if (m_lock[g]) begin lst[n] = g; n++; end
    if (n > 0 && ($urandom % 5) != 0) return 3'(2 * lst[$urandom % n] + ($urandom % 2));
    return 3'($urandom % 8);
  endfunction

  initial begin
    int cnt_a, cnt_k, cnt_d;
    bit alloc_seen, last_iss;
    logic [2:0] last_cu;
    logic [2:0] rot[3];
    rot[0] = 3'd0; rot[1] = 3'd4; rot[2] = 3'd6;

    // ---------- reset ----------
    idle_inputs();
    rst = 1;
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_pulses", {start_o, ack_o, alloc_o, dealloc_o, reject_o, err_o}, 0);
    model_reset();
    tick(); tick();
    rst = 0;
    tick();

    // ---------- basic alloc on CU 5 ----------
    buf_valid = 1; tick(); buf_valid = 0;
    check("basic_start", start_o, 1);
    tick();
    alloc_cu_valid = 1; alloc_cu_id = 3'd5; tick(); alloc_cu_valid = 0;
    tick();
    check("basic_alloc_valid", alloc_o, 1);
    check("basic_busy", busy_o, 8'b0011_0000);
    tick();
    check("basic_ack", ack_o, 1);
    alloc_done = 1; alloc_done_cu = 3'd4; tick(); alloc_done = 0;
    check("basic_busy_clear", busy_o, 0);
    tick();

    // ---------- waiting decision held while interface is busy ----------
    gpu_alloc_av = 0;
    buf_valid = 1; tick(); buf_valid = 0; tick();
    alloc_cu_valid = 1; alloc_cu_id = 3'd2; tick(); alloc_cu_valid = 0;
    cnt_a = 0; cnt_k = 0;
    repeat (10) begin tick(); cnt_a += int'(alloc_o); cnt_k += int'(ack_o); end
    check("hold_no_alloc", cnt_a, 0);
    check("hold_no_ack", cnt_k, 0);
    gpu_alloc_av = 1;
    cnt_a = 0; cnt_k = 0;
    repeat (3) begin tick(); cnt_a += int'(alloc_o); cnt_k += int'(ack_o); end
    check("hold_one_alloc", cnt_a, 1);
    check("hold_one_ack", cnt_k, 1);
    alloc_done = 1; alloc_done_cu = 3'd2; tick(); alloc_done = 0;
    tick();

    // ---------- starvation bound ----------
    gpu_dealloc_av = 1; last_iss = 0; last_cu = 0; alloc_seen = 0; cnt_d = 0;
    for (int k = 0; k < 20 && !alloc_seen; k++) begin
      gpu_cu          = rot[k % 3];
      dealloc_done    = last_iss;
      dealloc_done_cu = last_cu;
      buf_valid       = (k == 0);
      alloc_cu_valid  = (k == 2);
      alloc_cu_id     = 3'd3;
      tick();
      last_iss = e_dealloc;
      last_cu  = gpu_cu;
      if (k >= 3) begin
        if (alloc_o) alloc_seen = 1;
        else cnt_d += int'(dealloc_o);
      end
    end
    check("starve_alloc_issued", alloc_seen, 1);
    check("starve_dealloc_wins", cnt_d, STARVE_LIMIT);
    check("starve_cnt_cleared", 32'(dut.u_arb.starve_cnt_q), 0);
    drain();

    // ---------- reject ----------
    buf_valid = 1; tick(); buf_valid = 0; tick();
    alloc_cu_valid = 1; alloc_cu_id = 3'd6; alloc_rej = 1; tick();
    alloc_cu_valid = 0; alloc_rej = 0;
    tick();
    check("reject_valid", reject_o, 1);
    check("reject_busy", busy_o, 0);
    tick();
    check("reject_ack", ack_o, 1);
    tick();
    check("reject_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // ---------- concurrent completions and sticky error ----------
    gpu_dealloc_av = 1; gpu_cu = 3'd0; tick();
    gpu_cu = 3'd7; tick();
    gpu_dealloc_av = 0;
    check("conc_busy_locked", busy_o, 8'b1100_0011);
    alloc_done = 1; alloc_done_cu = 3'd1; dealloc_done = 1; dealloc_done_cu = 3'd7; tick();
    dealloc_done = 0;
    check("conc_busy_clear", busy_o, 0);
    check("conc_no_err", err_o, 0);
    tick();
    alloc_done = 0;
    check("conc_err_set", err_o, 1);
    repeat (3) tick();
    check("conc_err_sticky", err_o, 1);

    // ---------- reset while a decision is waiting ----------
    rst = 1; tick(); rst = 0;
    gpu_alloc_av = 0;
    buf_valid = 1; tick(); buf_valid = 0; tick();
    alloc_cu_valid = 1; alloc_cu_id = 3'd2; tick(); alloc_cu_valid = 0;
    tick();
    #3 rst = 1;
    #1;
    check("midrst_outputs", {start_o, ack_o, alloc_o, dealloc_o, reject_o, err_o, busy_o}, 0);
    check("midrst_waiting", dut.alloc_waiting_q, 0);
    model_reset();
    tick();
    rst = 0; idle_inputs();
    cnt_a = 0;
    repeat (5) begin
      tick();
      cnt_a += int'(start_o) + int'(ack_o) + int'(alloc_o) + int'(dealloc_o) + int'(reject_o);
    end
    check("midrst_no_pulses", cnt_a, 0);

    // ---------- randomized run ----------
    for (int k = 0; k < 1500; k++) begin
      rst             = (($urandom % 150) == 0);
      buf_valid       = (($urandom % 3) == 0);
      buf_avail       = (($urandom % 4) != 0);
      alloc_cu_valid  = (($urandom % 2) == 0);
      alloc_rej       = (($urandom % 4) == 0);
      alloc_cu_id     = 3'($urandom % 8);
      alloc_done      = (($urandom % 5) == 0);
      alloc_done_cu   = pick_done_cu();
      dealloc_done    = (($urandom % 5) == 0);
      dealloc_done_cu = pick_done_cu();
      gpu_alloc_av    = (($urandom % 4) != 0);
      gpu_dealloc_av  = (($urandom % 2) == 0);
      gpu_cu          = 3'($urandom % 8);
      tick();
    end
    rst = 0; idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
